// File: rtl/s1_sync_down_counter.sv
// s1_sync_down_counter: synchronous, loadable down counter / interval timer.
// Loads a start value, decrements once per enabled cycle and flags the
// terminal count with a one-cycle underflow pulse. By default the count is
// one-shot and ends in a one-cycle DONE state. Define DOWNCNT_AUTORELOAD_EN
// to reload the start value at each terminal count and keep running until
// stop is asserted.
module s1_sync_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             underflow
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;
  logic             accept;

  // stop always wins over start, so a simultaneous pair is a no-op
  assign accept = start & ~stop;

  // Next-state, count and pulse decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    underflow_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        // DONE only ever lasts one cycle
        state_d = StIdle;
        if (accept) begin
          reload_d = load_val;
          if (load_val == '0) begin
            // Zero-length count finishes immediately
            cnt_d       = '0;
            state_d     = StDone;
            underflow_d = 1'b1;
          end else begin
            cnt_d   = load_val;
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (stop) begin
          // Abort: count holds, no completion pulses
          state_d = StIdle;
        end else if (en) begin
          if (cnt_q > CntOne) begin
            cnt_d = cnt_q - CntOne;
          end else begin
            // Terminal count (zero here is unreachable, treated the same)
            underflow_d = 1'b1;
`ifdef DOWNCNT_AUTORELOAD_EN
            cnt_d   = reload_q;
            state_d = StRun;
`else
            cnt_d   = '0;
            state_d = StDone;
`endif
          end
        end
      end

      default: begin
        // Recover from the unused encoding
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
    end
  end

  // Outputs are direct decodes of registered state
  always_comb begin
    Q         = cnt_q;
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    underflow = underflow_q;
  end

endmodule
